// File: rtl/rcpu_decode_stage.sv
// RCPU decode / operand-fetch stage: register file, busy scoreboard with
// writeback bypass, and a single registered bundle slot toward the ALU.
module rcpu_decode_stage #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [15:0]         in_instr,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_instr,
    output logic [DATA_W-1:0]   out_operand1,
    output logic [DATA_W-1:0]   out_operand2,
    output logic [2:0]          out_rd,
    input  logic                wb_en,
    input  logic [2:0]          wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_mask
);

    logic [DATA_W-1:0]   regfile_q [NUM_REGS];
    logic [DATA_W-1:0]   regfile_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         out_instr_q, out_instr_d;
    logic [DATA_W-1:0]   out_op1_q, out_op1_d;
    logic [DATA_W-1:0]   out_op2_q, out_op2_d;
    logic [2:0]          out_rd_q, out_rd_d;

    logic [2:0]        rd, rs1, rs2;
    logic              use_imm;
    logic [5:0]        imm6;
    logic [DATA_W-1:0] imm, rs1_val, rs2_val;
    logic              rs1_busy, rs2_busy, rd_busy, hazard, accept;
    logic              wb_write;

    // Field decode and operand read; a writeback this cycle bypasses the file.
    always_comb begin
        rd      = in_instr[5:3];
        rs1     = in_instr[8:6];
        rs2     = in_instr[11:9];
        use_imm = in_instr[12];
        imm6    = {in_instr[15:13], in_instr[11:9]};
        imm     = {{(DATA_W-6){imm6[5]}}, imm6};

        rs1_val = (rs1 == 3'd0) ? '0 :
                  (wb_en && wb_addr == rs1) ? wb_data : regfile_q[rs1];
        rs2_val = (rs2 == 3'd0) ? '0 :
                  (wb_en && wb_addr == rs2) ? wb_data : regfile_q[rs2];

        // A register whose result is being written back this cycle is already free.
        rs1_busy = (rs1 != 3'd0) && busy_q[rs1] && !(wb_en && wb_addr == rs1);
        rs2_busy = (rs2 != 3'd0) && busy_q[rs2] && !(wb_en && wb_addr == rs2);
        rd_busy  = (rd  != 3'd0) && busy_q[rd]  && !(wb_en && wb_addr == rd);

        hazard   = rs1_busy || (!use_imm && rs2_busy) || rd_busy;
        in_ready = !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        wb_write = wb_en && (wb_addr != 3'd0);
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        regfile_d   = regfile_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_rd_d    = out_rd_q;

        if (wb_write) begin
            regfile_d[wb_addr] = wb_data;
            busy_d[wb_addr]    = 1'b0;
        end

        // Set after clear so a same-edge issue to the written register stays pending.
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr;
            out_op1_d   = rs1_val;
            out_op2_d   = use_imm ? imm : rs2_val;
            out_rd_d    = rd;
            if (rd != 3'd0) begin
                busy_d[rd] = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the register file is reset because architectural state must
            // read as zero after reset; most memories would be left unreset.
            regfile_q   <= '{default: '0};
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rd_q    <= '0;
        end else begin
            regfile_q   <= regfile_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_operand1 = out_op1_q;
    assign out_operand2 = out_op2_q;
    assign out_rd       = out_rd_q;
    assign busy_mask    = busy_q;

endmodule
